// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder: WIDTH bits resolved SEG bits per stage under a global valid/ready stall.
// Optional subtract mode is enabled with the PIPE_ADDER_SUB_EN macro (adds the sub input port).
module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SEG;

    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           ci);
        seg_add = {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};
    endfunction

    logic             advance_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             c_eff_s;

    logic             valid_r [STAGES];
    logic             carry_r [STAGES];
    logic [WIDTH-1:0] sum_r   [STAGES];
    logic [WIDTH-1:0] a_r     [STAGES];
    logic [WIDTH-1:0] b_r     [STAGES];
    logic             ovf_r;

    logic [WIDTH-1:0] src_a_s   [STAGES];
    logic [WIDTH-1:0] src_b_s   [STAGES];
    logic [WIDTH-1:0] src_sum_s [STAGES];
    logic             src_c_s   [STAGES];
    logic [SEG:0]     seg_s     [STAGES];
    logic [WIDTH-1:0] sum_nxt_s [STAGES];
    logic             carry_nxt_s [STAGES];
    logic             ovf_nxt_s;

    assign advance_s = !valid_r[STAGES-1] || out_ready;

    // Effective operand B and carry-in for the entering beat (subtract is a + ~b + 1).
    always_comb begin
`ifdef PIPE_ADDER_SUB_EN
        if (sub) begin
            b_eff_s = ~b;
            c_eff_s = 1'b1;
        end else begin
            b_eff_s = b;
            c_eff_s = c_in;
        end
`else
        b_eff_s = b;
        c_eff_s = c_in;
`endif
    end

    // Stage inputs: stage 0 takes the ports, stage k takes stage k-1's register.
    always_comb begin
        src_a_s[0]   = a;
        src_b_s[0]   = b_eff_s;
        src_c_s[0]   = c_eff_s;
        src_sum_s[0] = {WIDTH{1'b0}};
        for (int k = 1; k < STAGES; k++) begin
            src_a_s[k]   = a_r[k-1];
            src_b_s[k]   = b_r[k-1];
            src_c_s[k]   = carry_r[k-1];
            src_sum_s[k] = sum_r[k-1];
        end
    end

    // Per-stage segment add; each stage fills in its own SEG-bit slice of the sum.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            seg_s[k]       = seg_add(src_a_s[k][k*SEG +: SEG], src_b_s[k][k*SEG +: SEG], src_c_s[k]);
            sum_nxt_s[k]   = src_sum_s[k];
            sum_nxt_s[k][k*SEG +: SEG] = seg_s[k][SEG-1:0];
            carry_nxt_s[k] = seg_s[k][SEG];
        end
        ovf_nxt_s = (src_a_s[STAGES-1][WIDTH-1] == src_b_s[STAGES-1][WIDTH-1]) &&
                    (sum_nxt_s[STAGES-1][WIDTH-1] != src_a_s[STAGES-1][WIDTH-1]);
    end

    // Pipeline registers: whole pipe shifts together on advance, otherwise everything holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_r[k] <= 1'b0;
                carry_r[k] <= 1'b0;
                sum_r[k]   <= {WIDTH{1'b0}};
                a_r[k]     <= {WIDTH{1'b0}};
                b_r[k]     <= {WIDTH{1'b0}};
            end
            ovf_r <= 1'b0;
        end else if (advance_s) begin
            valid_r[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                valid_r[k] <= valid_r[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                carry_r[k] <= carry_nxt_s[k];
                sum_r[k]   <= sum_nxt_s[k];
                a_r[k]     <= src_a_s[k];
                b_r[k]     <= src_b_s[k];
            end
            ovf_r <= ovf_nxt_s;
        end
    end

    assign in_ready  = advance_s;
    assign out_valid = valid_r[STAGES-1];
    assign sum       = sum_r[STAGES-1];
    assign c_out     = carry_r[STAGES-1];
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed self-checking bench for pipe_adder (default 16-bit, 4 stages).
module tb_pipe_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    int total = 0;
    int bad   = 0;

    pipe_adder #(.WIDTH(WIDTH), .SEG(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef PIPE_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        a        = va;
        b        = vb;
        c_in     = vc;
        in_valid = 1'b1;
    endtask

    task automatic chk_out(input string tag, input logic [15:0] es, input logic ec, input logic eo);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_sum"},   {16'd0, sum},       {16'd0, es});
        chk({tag, "_cout"},  {31'd0, c_out},     {31'd0, ec});
        chk({tag, "_ovf"},   {31'd0, ovf},       {31'd0, eo});
    endtask

    // Single isolated beat, checking exact latency.
    task automatic one_beat(input string tag, input logic [15:0] va, input logic [15:0] vb,
                            input logic vc, input logic [15:0] es, input logic ec, input logic eo);
        drive(va, vb, vc);
        tick();
        in_valid = 1'b0;
        repeat (STAGES - 2) tick();
        chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        tick();
        chk_out(tag, es, ec, eo);
        tick();
    endtask

    logic [15:0] bp_a [6];
    logic [15:0] bp_b [6];
    logic        bp_c [6];
    logic [15:0] bp_s [6];
    logic        bp_co[6];
    logic        bp_ov[6];
    logic [15:0] bb_a [3];
    logic [15:0] bb_b [3];
    logic [15:0] bb_s [3];

    initial begin
        int idx;
        int sent;
        rst = 1'b1; in_valid = 1'b0; a = 16'h0; b = 16'h0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum",   {16'd0, sum},       32'd0);
        chk("rst_cout",  {31'd0, c_out},     32'd0);
        chk("rst_ovf",   {31'd0, ovf},       32'd0);
        chk("rst_ready", {31'd0, in_ready},  32'd1);

        // Basic add and back-to-back second beat
        drive(16'h0003, 16'h0004, 1'b0); tick();
        drive(16'h0009, 16'h0009, 1'b1); tick();
        in_valid = 1'b0;
        tick();
        chk("b2b_early", {31'd0, out_valid}, 32'd0);
        tick();
        chk_out("add37", 16'h0007, 1'b0, 1'b0);
        tick();
        chk_out("add9_9_1", 16'h0013, 1'b0, 1'b0);
        tick();
        chk("b2b_drain", {31'd0, out_valid}, 32'd0);

        // Carry wrap and signed overflow
        one_beat("wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        one_beat("ovfp",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Backpressure: six beats, stall 3 cycles once first result shows
        bp_a = '{16'h1234, 16'hA000, 16'h0F0F, 16'h5555, 16'h4000, 16'hFFFE};
        bp_b = '{16'h1111, 16'hA000, 16'hF0F0, 16'h2AAA, 16'h4000, 16'hFFFE};
        bp_c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        bp_s = '{16'h2345, 16'h4000, 16'h0000, 16'h7FFF, 16'h8000, 16'hFFFD};
        bp_co = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        bp_ov = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(bp_a[i], bp_b[i], bp_c[i]);
            tick();
        end
        drive(bp_a[4], bp_b[4], bp_c[4]);
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk_out("bp_hold", bp_s[0], bp_co[0], bp_ov[0]);
            tick();
        end
        out_ready = 1'b1;
        idx  = 0;
        sent = 4;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (out_valid) begin
                if (idx < 6) begin
                    chk_out("bp_seq", bp_s[idx], bp_co[idx], bp_ov[idx]);
                end else begin
                    chk("bp_extra", 32'd1, 32'd0);
                end
                idx++;
            end
            if (sent < 6) begin
                drive(bp_a[sent], bp_b[sent], bp_c[sent]);
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        chk("bp_count", idx, 32'd6);

        // Bubbles: beats on alternate cycles
        bb_a = '{16'h0001, 16'h00F0, 16'h0FFF};
        bb_b = '{16'h0002, 16'h0010, 16'h0001};
        bb_s = '{16'h0003, 16'h0100, 16'h1000};
        for (int c = 0; c < 10; c++) begin
            if ((c % 2 == 0) && (c < 6)) begin
                drive(bb_a[c/2], bb_b[c/2], 1'b0);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (c >= STAGES - 1) begin
                if (((c - 3) % 2 == 0) && (c - 3 < 6)) begin
                    chk_out("bub", bb_s[(c-3)/2], 1'b0, 1'b0);
                end else begin
                    chk("bub_gap", {31'd0, out_valid}, 32'd0);
                end
            end
        end

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            drive(16'h1000 + 16'(i), 16'h0001, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_sum",   {16'd0, sum},       32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mrst_stale", {31'd0, out_valid}, 32'd0);
        end
        one_beat("post_rst", 16'h0100, 16'h0023, 1'b0, 16'h0123, 1'b0, 1'b0);

`ifdef PIPE_ADDER_SUB_EN
        sub = 1'b1;
        one_beat("sub5_7", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        one_beat("sub_ovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        sub = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
